// File: rtl/opendap_mem_ap_apb_if.sv
// AP strobe/response signals from the SW-DP plus the APB master bus toward the target.
// slave: the MEM-AP's view; master: the DP/interconnect environment's view.
interface opendap_mem_ap_apb_if;
    logic [7:0]  ap_sel;
    logic [5:0]  ap_addr;
    logic [31:0] ap_wdata;
    logic        ap_wen;
    logic        ap_ren;
    logic        ap_abort;
    logic [31:0] ap_rdata;
    logic        ap_rdy;
    logic        ap_err;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport slave (
        input  ap_sel, ap_addr, ap_wdata, ap_wen, ap_ren, ap_abort,
        output ap_rdata, ap_rdy, ap_err,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport master (
        output ap_sel, ap_addr, ap_wdata, ap_wen, ap_ren, ap_abort,
        input  ap_rdata, ap_rdy, ap_err,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/opendap_mem_ap_apb.sv
// MEM-AP: decodes AP register accesses from the SW-DP; DRW/BDn become APB transfers,
// everything else (and any other AP number) completes locally in one cycle.
module opendap_mem_ap_apb #(
    parameter logic [7:0]  APSEL = 8'h00,
    parameter logic [31:0] IDR   = 32'h0477_0002,
    parameter logic [31:0] BASE  = 32'h0000_0003
) (
    input logic                   swclk,
    input logic                   rst_n,
    opendap_mem_ap_apb_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    localparam logic [5:0] AddrCsw  = 6'h00;
    localparam logic [5:0] AddrTar  = 6'h01;
    localparam logic [5:0] AddrDrw  = 6'h03;
    localparam logic [5:0] AddrBase = 6'h3E;
    localparam logic [5:0] AddrIdr  = 6'h3F;

    state_e      state_q, state_d;
    logic [31:0] tar_q, tar_d;
    logic [1:0]  addr_inc_q, addr_inc_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        is_drw_q, is_drw_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        sel_hit;
    logic        strobe;
    logic        is_apb;
    logic [31:0] csw_val;
    logic [31:0] local_rdata;

    assign sel_hit = (bus.ap_sel == APSEL);
    assign strobe  = (bus.ap_wen || bus.ap_ren) && (state_q == StIdle);
    assign is_apb  = sel_hit && ((bus.ap_addr == AddrDrw) || (bus.ap_addr[5:2] == 4'h1));
    assign csw_val = {24'h0, (state_q != StIdle), 1'b1, addr_inc_q, 1'b0, 3'b010};

    always_comb begin
        local_rdata = 32'h0;
        if (sel_hit) begin
            case (bus.ap_addr)
                AddrCsw:  local_rdata = csw_val;
                AddrTar:  local_rdata = tar_q;
                AddrBase: local_rdata = BASE;
                AddrIdr:  local_rdata = IDR;
                default:  local_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        tar_d      = tar_q;
        addr_inc_d = addr_inc_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        is_drw_d   = is_drw_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        if (bus.ap_abort) begin
            // Abort beats any simultaneous strobe; the APB transfer is simply abandoned.
            state_d = StIdle;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (strobe) begin
                        err_d = 1'b0;
                        if (is_apb) begin
                            state_d  = StSetup;
                            pwrite_d = bus.ap_wen;
                            pwdata_d = bus.ap_wdata;
                            is_drw_d = (bus.ap_addr == AddrDrw);
                            paddr_d  = (bus.ap_addr == AddrDrw) ?
                                       {tar_q[31:2], 2'b00} :
                                       {tar_q[31:4], bus.ap_addr[1:0], 2'b00};
                        end else if (bus.ap_wen) begin
                            if (sel_hit && bus.ap_addr == AddrCsw) begin
                                // Packed-transfer modes (2'b1x) are not supported.
                                addr_inc_d = bus.ap_wdata[5] ? 2'b00 : bus.ap_wdata[5:4];
                            end else if (sel_hit && bus.ap_addr == AddrTar) begin
                                tar_d = bus.ap_wdata;
                            end
                        end else begin
                            rdata_d = local_rdata;
                        end
                    end
                end
                StSetup: state_d = StAccess;
                StAccess: begin
                    if (bus.pready) begin
                        state_d = StIdle;
                        err_d   = bus.pslverr;
                        if (!pwrite_q) rdata_d = bus.prdata;
                        // Increment wraps inside the 1 KiB block.
                        if (is_drw_q && !bus.pslverr && addr_inc_q == 2'b01) begin
                            tar_d[9:2] = tar_q[9:2] + 8'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tar_q      <= 32'h0;
            addr_inc_q <= 2'b00;
            paddr_q    <= 32'h0;
            pwdata_q   <= 32'h0;
            pwrite_q   <= 1'b0;
            is_drw_q   <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tar_q      <= tar_d;
            addr_inc_q <= addr_inc_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            is_drw_q   <= is_drw_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.ap_rdata = rdata_q;
    assign bus.ap_rdy   = (state_q == StIdle);
    assign bus.ap_err   = err_q;
    assign bus.psel     = (state_q != StIdle);
    assign bus.penable  = (state_q == StAccess);
    assign bus.pwrite   = pwrite_q;
    assign bus.paddr    = paddr_q;
    assign bus.pwdata   = pwdata_q;

endmodule
